grf_wport_arb: RTL and testbench

GRF_WPORT_ARB -- requirements
Module: grf_wport_arb

---
 rtl/grf_wport_arb_pkg.sv | 17 +
 rtl/grf_arb_fifo.sv | 58 +++++
 rtl/grf_wport_arb.sv | 104 ++++++++++
 tb/tb_grf_wport_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wport_arb_pkg.sv
// Shared constants and payload type for the register-file write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package grf_wport_arb_pkg;

  localparam int GRF_FIFO_DEPTH = 2;
  localparam int GRF_AW         = 5;
  localparam int GRF_DW         = 32;
  localparam int GRF_NREG       = 1 << GRF_AW;

  // One queued late write: destination register and data.
  typedef struct packed {
    logic [GRF_AW-1:0] a3;
    logic [GRF_DW-1:0] wd;
  } wreq_t;

endpackage

// File: rtl/grf_arb_fifo.sv
// Two-entry FIFO holding late register-file writes until the port is free.
// Latency: an entry pushed at edge t is visible at the head from t+1.
// Backpressure: caller must not push when full or pop when empty.
module grf_arb_fifo
  import grf_wport_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wreq_t                         push_dat,
  input  logic                          pop,
  output wreq_t                         head,
  output logic [1:0]                    count,
  output logic [GRF_FIFO_DEPTH-1:0]     ent_vld,
  output logic [GRF_FIFO_DEPTH-1:0][GRF_AW-1:0] ent_a3
);

  wreq_t      mem [GRF_FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Per-entry validity and target register, used to build the pending mask.
  always_comb begin
    ent_vld = '0;
    ent_a3  = '0;
    for (int i = 0; i < GRF_FIFO_DEPTH; i++) begin
      ent_vld[i] = (cnt == 2'd2) || ((cnt == 2'd1) && (rd_ptr == 1'(i)));
      ent_a3[i]  = mem[i].a3;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/grf_wport_arb.sv
// Arbitrates the single GRF write port between the W stage and a queued late-result source.
// Latency: W writes pass through combinationally; late writes land no earlier than the cycle after acceptance.
// Backpressure: x_ready drops while the 2-entry queue is full; with GRF_ARB_STARVE_EN defined, stall_req asks the pipeline to freeze W so the queue drains.
module grf_wport_arb
  import grf_wport_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [4:0]  x_a3,
  input  logic [31:0] x_wd,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] pend_mask,
  output logic        stall_req
);

  wreq_t                                 head;
  wreq_t                                 push_dat;
  logic [1:0]                            count;
  logic [GRF_FIFO_DEPTH-1:0]             ent_vld;
  logic [GRF_FIFO_DEPTH-1:0][GRF_AW-1:0] ent_a3;
  logic                                  w_claim;
  logic                                  q_nonempty;
  logic                                  push;
  logic                                  pop;

  // Fullness uses the pre-pop count, so a full queue never accepts in the same cycle it drains.
  assign x_ready    = !rst && (count < 2'(GRF_FIFO_DEPTH));
  // Writes to r0 are accepted and dropped; they would never be observable.
  assign push       = x_valid && x_ready && (x_a3 != '0);
  assign push_dat   = '{a3: x_a3, wd: x_wd};
  assign w_claim    = !rst && w_we && (w_a3 != '0);
  assign q_nonempty = (count != 2'd0);
  assign pop        = !rst && !w_claim && q_nonempty;

  grf_arb_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .ent_vld  (ent_vld),
    .ent_a3   (ent_a3)
  );

  // Port mux: W has priority, otherwise the queue head, otherwise idle with zeroed address/data.
  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    if (w_claim) begin
      grf_we = 1'b1;
      grf_a3 = w_a3;
      grf_wd = w_wd;
    end else if (pop) begin
      grf_we = 1'b1;
      grf_a3 = head.a3;
      grf_wd = head.wd;
    end
  end

  // Pending mask: one bit per register targeted by a live queue entry; r0 never pending.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < GRF_FIFO_DEPTH; i++) begin
      if (ent_vld[i]) pend_mask[ent_a3[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

`ifdef GRF_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  logic       stall_q;

  // Count consecutive cycles the queue waits behind W; request a stall at the limit until the next pop.
  always_ff @(posedge clk) begin
    if (rst || !q_nonempty || pop) begin
      starve_cnt <= 4'd0;
      stall_q    <= 1'b0;
    end else begin
      if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      if (starve_cnt >= 4'(STARVE_LIMIT - 1)) stall_q <= 1'b1;
    end
  end

  assign stall_req = stall_q;
`else
  // Without the guard the queue only drains in W-idle cycles; the limit has no effect.
  logic [3:0] unused_starve_limit;
  assign unused_starve_limit = 4'(STARVE_LIMIT);
  assign stall_req           = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wport_arb.sv
// Directed self-checking bench for grf_wport_arb.
// Inputs are driven 1 time unit after the rising edge and outputs sampled 1 unit later.
// Starvation expectations follow whether GRF_ARB_STARVE_EN is defined for the build.
module tb_grf_wport_arb;

`ifdef GRF_ARB_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        x_valid;
  logic        x_ready;
  logic [4:0]  x_a3;
  logic [31:0] x_wd;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] pend_mask;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;

  grf_wport_arb #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_a3      (w_a3),
    .w_wd      (w_wd),
    .x_valid   (x_valid),
    .x_ready   (x_ready),
    .x_a3      (x_a3),
    .x_wd      (x_wd),
    .grf_we    (grf_we),
    .grf_a3    (grf_a3),
    .grf_wd    (grf_wd),
    .pend_mask (pend_mask),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A W write to a register that still has a queued late write is a protocol violation.
  task automatic proto();
    logic hit;
    hit = (w_we && (w_a3 != 5'd0)) ? pend_mask[w_a3] : 1'b0;
    chk("proto_w_to_pending", {31'd0, hit}, 32'd0);
  endtask

  task automatic tick();
    proto();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic xv, input logic [4:0] xa, input logic [31:0] xd);
    w_we    = we;
    w_a3    = wa;
    w_wd    = wd;
    x_valid = xv;
    x_a3    = xa;
    x_wd    = xd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    w_we = 1'b0; w_a3 = '0; w_wd = '0;
    x_valid = 1'b0; x_a3 = '0; x_wd = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset: outputs forced off even with W asserting.
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd3, 32'h3);
    chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("rst_x_ready", {31'd0, x_ready}, 32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("post_rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("post_rst_pend", pend_mask, 32'd0);
    chk("post_rst_stall", {31'd0, stall_req}, 32'd0);
    chk("post_rst_x_ready", {31'd0, x_ready}, 32'd1);

    // W write r5=0x1234 with an empty queue goes straight through.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    chk("w_only_we", {31'd0, grf_we}, 32'd1);
    chk("w_only_a3", {27'd0, grf_a3}, 32'd5);
    chk("w_only_wd", grf_wd, 32'h1234);
    chk("w_only_x_ready", {31'd0, x_ready}, 32'd1);
    tick();

    // Late write r8=0xAA with W idle: no bypass, lands next cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'hAA);
    chk("x8_t_ready", {31'd0, x_ready}, 32'd1);
    chk("x8_t_no_bypass", {31'd0, grf_we}, 32'd0);
    chk("x8_t_pend", pend_mask, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("x8_t1_pend", pend_mask, 32'h0000_0100);
    chk("x8_t1_we", {31'd0, grf_we}, 32'd1);
    chk("x8_t1_a3", {27'd0, grf_a3}, 32'd8);
    chk("x8_t1_wd", grf_wd, 32'hAA);
    tick();
    chk("x8_t2_pend", pend_mask, 32'd0);
    chk("x8_t2_we", {31'd0, grf_we}, 32'd0);
    chk("x8_t2_a3", {27'd0, grf_a3}, 32'd0);

    // Fill the queue behind a busy W, hold a third request until it drains.
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd9, 32'h99);
    chk("fill_a_ready", {31'd0, x_ready}, 32'd1);
    chk("fill_a_grf_a3", {27'd0, grf_a3}, 32'd5);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd10, 32'h10);
    chk("fill_b_ready", {31'd0, x_ready}, 32'd1);
    chk("fill_b_pend", pend_mask, 32'h0000_0200);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd11, 32'h11);
    chk("full_ready", {31'd0, x_ready}, 32'd0);
    chk("full_pend", pend_mask, 32'h0000_0600);
    chk("full_grf_a3", {27'd0, grf_a3}, 32'd5);
    chk("full_grf_wd", grf_wd, 32'h55);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h11);
    chk("drain1_ready_prepop", {31'd0, x_ready}, 32'd0);
    chk("drain1_we", {31'd0, grf_we}, 32'd1);
    chk("drain1_a3", {27'd0, grf_a3}, 32'd9);
    chk("drain1_wd", grf_wd, 32'h99);
    tick();
    chk("drain2_ready", {31'd0, x_ready}, 32'd1);
    chk("drain2_a3", {27'd0, grf_a3}, 32'd10);
    chk("drain2_wd", grf_wd, 32'h10);
    chk("drain2_pend", pend_mask, 32'h0000_0400);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drain3_a3", {27'd0, grf_a3}, 32'd11);
    chk("drain3_wd", grf_wd, 32'h11);
    chk("drain3_pend", pend_mask, 32'h0000_0800);
    chk("drain3_stall", {31'd0, stall_req}, 32'd0);
    tick();
    chk("drain_done_we", {31'd0, grf_we}, 32'd0);
    chk("drain_done_pend", pend_mask, 32'd0);

    // Request to r0 is accepted and discarded.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    chk("r0_ready", {31'd0, x_ready}, 32'd1);
    chk("r0_pend", pend_mask, 32'd0);
    chk("r0_we_t", {31'd0, grf_we}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("r0_we_t1", {31'd0, grf_we}, 32'd0);
    chk("r0_pend_t1", pend_mask, 32'd0);
    tick();
    chk("r0_we_t2", {31'd0, grf_we}, 32'd0);

    // Starvation: one queued entry behind four busy W cycles.
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd12, 32'hC);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    chk("starve_pend", pend_mask, 32'h0000_1000);
    for (int i = 0; i < 4; i++) begin
      chk("starve_busy_stall", {31'd0, stall_req}, 32'd0);
      tick();
    end
    chk("starve_stall_set", {31'd0, stall_req}, {31'd0, STARVE_ON});
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("starve_stall_hold", {31'd0, stall_req}, {31'd0, STARVE_ON});
    chk("starve_pop_a3", {27'd0, grf_a3}, 32'd12);
    chk("starve_pop_wd", grf_wd, 32'hC);
    tick();
    chk("starve_stall_clr", {31'd0, stall_req}, 32'd0);
    chk("starve_empty_pend", pend_mask, 32'd0);

    // Duplicate targets share one mask bit; order preserved.
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h71);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h72);
    chk("dup_ready", {31'd0, x_ready}, 32'd1);
    chk("dup_pend1", pend_mask, 32'h0000_0080);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("dup_pend2", pend_mask, 32'h0000_0080);
    chk("dup_first_wd", grf_wd, 32'h71);
    tick();
    chk("dup_second_wd", grf_wd, 32'h72);
    chk("dup_second_a3", {27'd0, grf_a3}, 32'd7);
    chk("dup_pend3", pend_mask, 32'h0000_0080);
    tick();
    chk("dup_done_pend", pend_mask, 32'd0);

    // Reset with two queued entries drops them.
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd13, 32'hD);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd14, 32'hE);
    tick();
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    chk("qrst_full_pend", pend_mask, 32'h0000_6000);
    rst = 1'b1;
    #1;
    chk("qrst_during_we", {31'd0, grf_we}, 32'd0);
    chk("qrst_during_ready", {31'd0, x_ready}, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("qrst_after_pend", pend_mask, 32'd0);
    chk("qrst_after_we", {31'd0, grf_we}, 32'd0);
    chk("qrst_after_stall", {31'd0, stall_req}, 32'd0);
    chk("qrst_after_ready", {31'd0, x_ready}, 32'd1);
    tick();
    chk("qrst_after_we2", {31'd0, grf_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
